mux4_drain_seq: RTL and testbench

Upstream sequencer for the 4:1 output mux of the matrix-multiply datapath. It accepts one block of four parallel WIDTH-bit fixed-point results from the multiply core through a valid/ready handshake and holds them on the mux data inputs. It then steps a one-hot select through four consecutive cycles. A valid/last strobe is emitted aligned to the mux's registered output, so the downstream consumer sees one word per cycle.

---
 rtl/mm_pkg.sv | 35 +++
 rtl/mux4_drain_seq_valid_delay.sv | 44 ++++
 rtl/mux4_drain_seq.sv | 130 +++++++++++++
 tb/tb_mux4_drain_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply output path.
//   DEF_WIDTH   : default data word width (Q8.8 fixed point, 16 bits)
//   state_e     : drain sequencer states {IDLE, DRAIN}
//   SEL_*       : one-hot select codes for the 4:1 output mux
//   beat_to_sel : maps a 2-bit beat index onto its one-hot select code
// ---------------------------------------------------------------------------
package mm_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_0    = 4'b0001;
    localparam logic [3:0] SEL_1    = 4'b0010;
    localparam logic [3:0] SEL_2    = 4'b0100;
    localparam logic [3:0] SEL_3    = 4'b1000;

    function automatic logic [3:0] beat_to_sel(input logic [1:0] beat);
        logic [3:0] sel;
        case (beat)
            2'd0:    sel = SEL_0;
            2'd1:    sel = SEL_1;
            2'd2:    sel = SEL_2;
            default: sel = SEL_3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux4_drain_seq_valid_delay.sv
// ---------------------------------------------------------------------------
// valid_delay
// DEPTH-deep, 2-bit-wide shift register with asynchronous active-low clear.
// Carries the {last, valid} strobes alongside the downstream mux pipeline so
// the strobes line up with the mux's registered output word.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low clear of every stage
//   i_strb  : strobe pair entering the line, bit0 = valid, bit1 = last
//   o_strb  : strobe pair after DEPTH cycles (combinational when DEPTH = 0)
// ---------------------------------------------------------------------------
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_strb,
    output logic [1:0] o_strb
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Zero-latency mux: strobes are taken straight from the state.
            assign o_strb = i_strb;
        end else begin : g_line
            logic [1:0] r_sr [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_sr[i] <= 2'b00;
                    end
                end else begin
                    r_sr[0] <= i_strb;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_strb = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mux4_drain_seq.sv
// ---------------------------------------------------------------------------
// mux4_drain_seq
// Upstream sequencer for the 4:1 output mux of the matrix-multiply datapath.
// Accepts a block of four WIDTH-bit words over valid/ready, holds them on the
// mux data inputs and walks a one-hot select across four consecutive cycles.
// out_valid / out_last are delayed by MUX_LAT so they line up with the mux's
// output word.
//
// Handshake: a block transfers on a rising edge where in_valid && in_ready.
// in_ready is high in IDLE and on the last drain beat; in_valid while
// in_ready is low is ignored, so upstream must hold in_valid and data until it
// sees in_ready. The downstream side has no backpressure.
//
// Parameters:
//   WIDTH    : data word width
//   MUX_LAT  : select-to-mux-output latency in cycles (0..4)
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream block handshake
//   in_data_0..3         : incoming block of four words
//   input_0..3           : held words driving the mux data inputs
//   select               : one-hot mux select, bit k selects input_k
//   out_valid / out_last : word strobe and end-of-block marker at mux output
//   dbg_state, dbg_beat  : FSM state and beat counter for observation
// Configuration macro:
//   DRAIN_REVERSE_EN     : when defined, drain order is input_3 .. input_0
// ---------------------------------------------------------------------------
module mux4_drain_seq
    import mm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUX_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data_0,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic [WIDTH-1:0] in_data_3,
    output logic [WIDTH-1:0] input_0,
    output logic [WIDTH-1:0] input_1,
    output logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] input_3,
    output logic [3:0]       select,
    output logic             out_valid,
    output logic             out_last,
    output state_e           dbg_state,
    output logic [1:0]       dbg_beat
);

    state_e           r_state;
    logic [1:0]       r_beat;
    logic [WIDTH-1:0] r_hold [4];

    logic             w_last_beat;
    logic             w_ready;
    logic             w_hs;
    logic [1:0]       w_sel_idx;
    logic [1:0]       w_strb;
    logic [1:0]       w_strb_dly;

    assign w_last_beat = (r_state == DRAIN) && (r_beat == 2'd3);

    // rst_n gates ready so upstream sees in_ready = 0 for the whole time
    // reset is held, yet ready rises in the same cycle reset is released.
    assign w_ready = rst_n && ((r_state == IDLE) || w_last_beat);
    assign w_hs    = in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            if (w_hs) begin
                // A new block may land on beat 3: the mux samples the old
                // input_3 / input_0 on this same edge, so nothing is lost.
                r_hold[0] <= in_data_0;
                r_hold[1] <= in_data_1;
                r_hold[2] <= in_data_2;
                r_hold[3] <= in_data_3;
                r_state   <= DRAIN;
                r_beat    <= 2'd0;
            end else if (r_state == DRAIN) begin
                r_beat <= r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    r_state <= IDLE;
                end
            end
        end
    end

`ifdef DRAIN_REVERSE_EN
    // Reverse drain: beat b selects input_(3-b); 2-bit inversion is 3-b.
    assign w_sel_idx = ~r_beat;
`else
    assign w_sel_idx = r_beat;
`endif

    assign select = (r_state == DRAIN) ? beat_to_sel(w_sel_idx) : SEL_NONE;

    // bit0: a word is on the mux this cycle; bit1: it is the block's last.
    assign w_strb = {w_last_beat, (r_state == DRAIN)};

    valid_delay #(
        .DEPTH (MUX_LAT)
    ) u_valid_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_strb (w_strb),
        .o_strb (w_strb_dly)
    );

    assign out_valid = w_strb_dly[0];
    assign out_last  = w_strb_dly[1];
    assign in_ready  = w_ready;

    assign input_0 = r_hold[0];
    assign input_1 = r_hold[1];
    assign input_2 = r_hold[2];
    assign input_3 = r_hold[3];

    assign dbg_state = r_state;
    assign dbg_beat  = r_beat;

endmodule

// File: tb/tb_mux4_drain_seq.sv
// ---------------------------------------------------------------------------
// tb_mux4_drain_seq
// Drives three copies of mux4_drain_seq (MUX_LAT = 0, 1, 3) from one stimulus
// stream. Each copy feeds a small model of the downstream mux (select-ORed
// word, delayed MUX_LAT cycles). Expected output words are queued when a
// block is accepted and popped when the copy raises out_valid.
// Honours DRAIN_REVERSE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mux4_drain_seq;
    import mm_pkg::*;

    localparam int W  = 16;
    localparam int EW = 33;   // {cycle[15:0], last, word[15:0]}
    localparam int NI = 3;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         in_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [NI-1:0] rdy_a, val_a, last_a;
    logic [3:0]   sel_a [NI];
    logic [W-1:0] h_a   [NI][4];
    state_e       st_a  [NI];
    logic [1:0]   bt_a  [NI];

    mux4_drain_seq #(.WIDTH(W), .MUX_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[0]),
        .in_data_0(d0), .in_data_1(d1), .in_data_2(d2), .in_data_3(d3),
        .input_0(h_a[0][0]), .input_1(h_a[0][1]), .input_2(h_a[0][2]), .input_3(h_a[0][3]),
        .select(sel_a[0]), .out_valid(val_a[0]), .out_last(last_a[0]),
        .dbg_state(st_a[0]), .dbg_beat(bt_a[0])
    );

    mux4_drain_seq #(.WIDTH(W), .MUX_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[1]),
        .in_data_0(d0), .in_data_1(d1), .in_data_2(d2), .in_data_3(d3),
        .input_0(h_a[1][0]), .input_1(h_a[1][1]), .input_2(h_a[1][2]), .input_3(h_a[1][3]),
        .select(sel_a[1]), .out_valid(val_a[1]), .out_last(last_a[1]),
        .dbg_state(st_a[1]), .dbg_beat(bt_a[1])
    );

    mux4_drain_seq #(.WIDTH(W), .MUX_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[2]),
        .in_data_0(d0), .in_data_1(d1), .in_data_2(d2), .in_data_3(d3),
        .input_0(h_a[2][0]), .input_1(h_a[2][1]), .input_2(h_a[2][2]), .input_3(h_a[2][3]),
        .select(sel_a[2]), .out_valid(val_a[2]), .out_last(last_a[2]),
        .dbg_state(st_a[2]), .dbg_beat(bt_a[2])
    );

    // ---------------- downstream mux model ----------------
    logic [W-1:0] sel_word [NI];
    logic [W-1:0] mpipe    [NI][3];

    always_comb begin
        for (int g = 0; g < NI; g++) begin
            sel_word[g] = '0;
            for (int k = 0; k < 4; k++) begin
                if (sel_a[g][k]) sel_word[g] = sel_word[g] | h_a[g][k];
            end
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            mpipe[g][0] <= sel_word[g];
            mpipe[g][1] <= mpipe[g][0];
            mpipe[g][2] <= mpipe[g][1];
        end
    end

    function automatic logic [W-1:0] mux_out(input int g);
        if (lat_of(g) == 0) return sel_word[g];
        return mpipe[g][lat_of(g)-1];
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q0 [$];
    logic [EW-1:0] exp_q1 [$];
    logic [EW-1:0] exp_q2 [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state for ready/select/hold, shared by all three copies.
    int           busy_until = 0;     // first cycle in which in_ready is 1
    int           last_hs    = -100;  // cycle in which beat 0 of the last block sits
    logic [W-1:0] held [4];

    function automatic void check(input string tag, input logic [31:0] obs,
                                  input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endfunction

    function automatic void q_push(input int g, input logic [EW-1:0] e);
        case (g)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int g);
        case (g)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [EW-1:0] q_pop(input int g);
        case (g)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic logic [EW-1:0] q_front(input int g);
        case (g)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    // ---------------- per-cycle monitor ----------------
    always @(negedge clk) begin : monitor
        int           e, d, ri, lat;
        logic [3:0]   exp_sel;
        logic [EW-1:0] ent;
        logic [15:0]  e16;
        e   = cyc;
        e16 = e[15:0];
        d   = e - last_hs;
`ifdef DRAIN_REVERSE_EN
        ri = 3 - d;
`else
        ri = d;
`endif
        exp_sel = (d >= 0 && d <= 3) ? (4'b0001 << ri) : 4'b0000;
        for (int g = 0; g < NI; g++) begin
            lat = lat_of(g);
            check($sformatf("in_ready_lat%0d", lat), {31'b0, rdy_a[g]},
                  {31'b0, (rst_n === 1'b1) && (e >= busy_until)});
            check($sformatf("select_lat%0d", lat), {28'b0, sel_a[g]}, {28'b0, exp_sel});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("input_%0d_lat%0d", k, lat), {16'b0, h_a[g][k]}, {16'b0, held[k]});
            end
            if (val_a[g] === 1'b1) begin
                if (q_size(g) == 0) begin
                    check($sformatf("spurious_valid_lat%0d", lat), {31'b0, val_a[g]}, 32'd0);
                end else begin
                    ent = q_pop(g);
                    check($sformatf("valid_cycle_lat%0d", lat), {16'b0, e16}, {16'b0, ent[32:17]});
                    check($sformatf("word_lat%0d", lat), {16'b0, mux_out(g)}, {16'b0, ent[15:0]});
                    check($sformatf("last_lat%0d", lat), {31'b0, last_a[g]}, {31'b0, ent[16]});
                end
            end else begin
                check($sformatf("last_idle_lat%0d", lat), {31'b0, last_a[g]}, 32'd0);
                if (q_size(g) > 0) begin
                    ent = q_front(g);
                    if (ent[32:17] <= e16) begin
                        check($sformatf("missing_valid_lat%0d", lat), {31'b0, val_a[g]}, 32'd1);
                        ent = q_pop(g);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Called one step after a falling edge. Offers the block until the
    // reference model says it is taken; with junk set, the data bus carries
    // random words during the cycles in which the block cannot be accepted.
    task automatic send_block(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] w3,
                              input bit junk);
        logic [W-1:0] w [4];
        logic [W-1:0] word;
        int t, guard;
        bit done;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        done  = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        while (!done) begin
            if (cyc >= busy_until) begin
                d0 = w[0]; d1 = w[1]; d2 = w[2]; d3 = w[3];
                t = cyc + 1;
                for (int g = 0; g < NI; g++) begin
                    for (int k = 0; k < 4; k++) begin
`ifdef DRAIN_REVERSE_EN
                        word = w[3-k];
`else
                        word = w[k];
`endif
                        q_push(g, {16'(t + lat_of(g) + k), (k == 3), word});
                    end
                end
                for (int k = 0; k < 4; k++) held[k] = w[k];
                last_hs    = t;
                busy_until = t + 3;
                done       = 1'b1;
                tick();
            end else begin
                if (junk) begin
                    d0 = W'($urandom_range(0, 16'hFFFF));
                    d1 = W'($urandom_range(0, 16'hFFFF));
                    d2 = W'($urandom_range(0, 16'hFFFF));
                    d3 = W'($urandom_range(0, 16'hFFFF));
                end else begin
                    d0 = w[0]; d1 = w[1]; d2 = w[2]; d3 = w[3];
                end
                guard++;
                if (guard > 20) begin
                    check("send_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
                tick();
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int k = 0; k < 4; k++) held[k] = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single block.
        send_block(16'h0400, 16'h0300, 16'h0200, 16'h0100, 1'b0);
        idle(8);

        // Two blocks back-to-back, in_valid held throughout.
        send_block(16'h0400, 16'h0300, 16'h0200, 16'h0100, 1'b0);
        send_block(16'h0A0B, 16'h0A0C, 16'h0A0D, 16'h0A0E, 1'b0);
        idle(8);

        // Offer with changing data while busy: only beat-3 data is taken.
        send_block(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
        send_block(16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b1);
        idle(8);

        // Reset on beat 2 of a block.
        send_block(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_ready_lat%0d", lat_of(g)), {31'b0, rdy_a[g]}, 32'd0);
            check($sformatf("rst_select_lat%0d", lat_of(g)), {28'b0, sel_a[g]}, 32'd0);
            check($sformatf("rst_valid_lat%0d", lat_of(g)), {31'b0, val_a[g]}, 32'd0);
            check($sformatf("rst_last_lat%0d", lat_of(g)), {31'b0, last_a[g]}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rst_input_%0d_lat%0d", k, lat_of(g)), {16'b0, h_a[g][k]}, 32'd0);
            end
        end
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int k = 0; k < 4; k++) held[k] = '0;
        last_hs    = -100;
        busy_until = 0;
        // Block already offered when reset releases.
        in_valid = 1'b1;
        d0 = 16'hC001; d1 = 16'hC002; d2 = 16'hC003; d3 = 16'hC004;
        tick();
        tick();
        rst_n = 1'b1;
        send_block(16'hC001, 16'hC002, 16'hC003, 16'hC004, 1'b0);
        idle(8);

        // Random blocks with random gaps (gap 0 = back-to-back).
        repeat (5) begin
            send_block(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                       W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                       1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        idle(10);

        for (int g = 0; g < NI; g++) begin
            check($sformatf("queue_drained_lat%0d", lat_of(g)), q_size(g), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
